// File: rtl/alu_pkg.sv
// Shared definitions for the Alu command path: opcode encodings, the
// legality test used to reject unknown opcodes, and the issuer FSM states.
// The Alu and its bench use the same opcode constants.
package alu_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] PARITY   = 3'd0;
  localparam logic [OPC_W-1:0] ROTR     = 3'd1;
  localparam logic [OPC_W-1:0] ROTL     = 3'd2;
  localparam logic [OPC_W-1:0] POPCOUNT = 3'd3;
  localparam logic [OPC_W-1:0] BITREV   = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes 101..111 have no Alu operation behind them.
  function automatic logic is_legal_opcode(input logic [OPC_W-1:0] op);
    return (op <= BITREV);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the Alu issuer.
// Ports:
//   clk, rst    clock and asynchronous active-high reset (flushes pointers)
//   push, wdata write one entry (ignored when full)
//   pop, rdata  rdata always shows the head; pop retires it (ignored when empty)
//   full, empty occupancy flags
//   level       number of entries held, 0..DEPTH
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit so that equal indices can be told apart
  // as either empty (same wrap) or full (opposite wrap).
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command-side front end for the clocked Alu. Buffers {opcode,A,B} commands,
// issues them one at a time, waits out the Alu latency and returns each
// result on a valid/ready response port. Illegal opcodes are answered with
// an error response and never reach the Alu.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready = !full)
//   cmd_opcode, cmd_a, cmd_b       command fields
//   alu_opcode, alu_a, alu_b       registered Alu inputs
//   alu_result                     Alu output
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_opcode, rsp_error response fields
//   busy                           FSM not idle or FIFO not empty
//   fifo_level                     commands currently buffered
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 256,
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [OPC_W-1:0]             cmd_opcode,
  input  logic [DATA_WIDTH-1:0]        cmd_a,
  input  logic [DATA_WIDTH-1:0]        cmd_b,
  output logic [OPC_W-1:0]             alu_opcode,
  output logic [DATA_WIDTH-1:0]        alu_a,
  output logic [DATA_WIDTH-1:0]        alu_b,
  input  logic [DATA_WIDTH-1:0]        alu_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [OPC_W-1:0]             rsp_opcode,
  output logic                         rsp_error,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int ENTRY_W = OPC_W + 2*DATA_WIDTH;
  // Counter must hold ALU_LATENCY; the +2 keeps it at least one bit wide.
  localparam int CNT_W   = $clog2(ALU_LATENCY + 2);

  logic [ENTRY_W-1:0]    head;
  logic [OPC_W-1:0]      head_op;
  logic [DATA_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_b;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  load_alu;
  logic                  load_err;
  logic                  capture;

  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({cmd_opcode, cmd_a, cmd_b}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign head_op = head[ENTRY_W-1 -: OPC_W];
  assign head_a  = head[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign head_b  = head[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Only IDLE pops, so a new command is never issued until the previous
  // response has been handed over; the Alu sees one command at a time.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    load_alu   = 1'b0;
    load_err   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (is_legal_opcode(head_op)) begin
            load_alu   = 1'b1;
            cnt_next   = CNT_W'(ALU_LATENCY);
            state_next = WAIT;
          end else begin
            load_err   = 1'b1;
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Alu-side and response registers. The Alu inputs only change on a legal
  // issue, so an illegal command leaves them at their previous values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_data   <= '0;
      rsp_opcode <= '0;
      rsp_error  <= 1'b0;
    end else begin
      if (load_alu) begin
        alu_opcode <= head_op;
        alu_a      <= head_a;
        alu_b      <= head_b;
      end
      if (load_err) begin
        rsp_data   <= '0;
        rsp_error  <= 1'b1;
        rsp_opcode <= head_op;
      end
      // alu_opcode is still holding the issued opcode at capture time.
      if (capture) begin
        rsp_data   <= alu_result;
        rsp_error  <= 1'b0;
        rsp_opcode <= alu_opcode;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) || !empty;

endmodule
